// File: rtl/msrh_csu_pkg.sv
// msrh_csu_pkg: shared CSU constants for the machine-mode CSR file.
//   XLEN_W            default data width (32 or 64)
//   CSR_*             12-bit CSR addresses
//   MSTATUS_*         mstatus field bit positions
//   misa_val()        constant misa contents for a given XLEN (RV{32,64}IM)
package msrh_csu_pkg;

    localparam int XLEN_W = 64;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // MXL in the top two bits, extensions I (bit 8) and M (bit 12).
    function automatic logic [63:0] misa_val(input int xlen);
        logic [63:0] v;
        v = 64'h0000_0000_0000_1100;
        if (xlen == 64) v[63:62] = 2'b10;
        else            v[31:30] = 2'b01;
        return v;
    endfunction

endpackage

// File: rtl/msrh_csr_file_if.sv
// CSR file bus interfaces.
//   csr_rd_if   : valid/addr from requester, data returned combinationally
//   csr_wr_if   : valid/addr/data, final value (requester does any RMW)
//   csr_info_if : mepc/mtvec/mstatus_mie broadcast from the CSR file
interface csr_rd_if #(parameter int XLEN_W = msrh_csu_pkg::XLEN_W);
    logic              valid;
    logic [11:0]       addr;
    logic [XLEN_W-1:0] data;
    modport master (output valid, output addr, input  data);
    modport slave  (input  valid, input  addr, output data);
endinterface

interface csr_wr_if #(parameter int XLEN_W = msrh_csu_pkg::XLEN_W);
    logic              valid;
    logic [11:0]       addr;
    logic [XLEN_W-1:0] data;
    modport master (output valid, output addr, output data);
    modport slave  (input  valid, input  addr, input  data);
endinterface

interface csr_info_if #(parameter int XLEN_W = msrh_csu_pkg::XLEN_W);
    logic [XLEN_W-1:0] mepc;
    logic [XLEN_W-1:0] mtvec;
    logic              mstatus_mie;
    modport master (output mepc, output mtvec, output mstatus_mie);
    modport slave  (input  mepc, input  mtvec, input  mstatus_mie);
endinterface

// File: rtl/msrh_csr_file_counter.sv
// msrh_csr_counter: 64-bit free-running counter with CSR write override.
//   i_clk, i_reset_n   clock, async active-low reset (clears to 0)
//   i_inc              amount added every cycle
//   i_wr_lo/i_wr_hi    write low/high half (XLEN_W==32) or whole counter (wr_lo, XLEN_W==64)
//   i_wr_data          write value
//   o_cnt              current count
// Any write in a cycle replaces the increment for that cycle.
module msrh_csr_counter #(
    parameter int XLEN_W = 64,
    parameter int INC_W  = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [INC_W-1:0]  i_inc,
    input  logic              i_wr_lo,
    input  logic              i_wr_hi,
    input  logic [XLEN_W-1:0] i_wr_data,
    output logic [63:0]       o_cnt
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_nxt;

    generate
        if (XLEN_W == 32) begin : g_x32
            always_comb begin
                cnt_nxt = cnt_q + 64'(i_inc);
                if (i_wr_lo || i_wr_hi) begin
                    cnt_nxt = cnt_q;
                    if (i_wr_lo) cnt_nxt[31:0]  = i_wr_data[31:0];
                    if (i_wr_hi) cnt_nxt[63:32] = i_wr_data[31:0];
                end
            end
        end else begin : g_x64
            // No high half exists at this width.
            logic unused_wr_hi;
            assign unused_wr_hi = i_wr_hi;
            always_comb begin
                cnt_nxt = cnt_q + 64'(i_inc);
                if (i_wr_lo) cnt_nxt = 64'(i_wr_data);
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_nxt;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/msrh_csr_file.sv
// msrh_csr_file: machine-mode CSR register file.
//   i_clk, i_reset_n      clock, async active-low reset
//   rd   (csr_rd_if.slave)     combinational read port, unimplemented -> 0
//   wr   (csr_wr_if.slave)     registered write port, RO/unimplemented ignored
//   i_trap_*              exception taken at commit (mepc/mcause/mtval/mstatus)
//   i_mret_valid          mret committed
//   i_commit_cnt          instructions retired this cycle (minstret)
//   info (csr_info_if.master)  registered mepc/mtvec/mstatus.MIE
// Build option: define MSRH_CSR_COUNTERS_EN to implement mcycle/minstret
// (and the high halves at XLEN_W==32); otherwise they read 0 and ignore writes.
module msrh_csr_file
    import msrh_csu_pkg::*;
#(
    parameter int HART_ID = 0,
    parameter int CMT_W   = 2,
    parameter int XLEN_W  = msrh_csu_pkg::XLEN_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    csr_rd_if.slave                    rd,
    csr_wr_if.slave                    wr,
    input  logic                       i_trap_valid,
    input  logic [XLEN_W-1:0]          i_trap_cause,
    input  logic [XLEN_W-1:0]          i_trap_pc,
    input  logic [XLEN_W-1:0]          i_trap_tval,
    input  logic                       i_mret_valid,
    input  logic [$clog2(CMT_W+1)-1:0] i_commit_cnt,
    csr_info_if.master                 info
);

    localparam int CNT_W = $clog2(CMT_W+1);
    localparam logic [XLEN_W-1:0] MEPC_MASK  = {{(XLEN_W-1){1'b1}}, 1'b0};
    localparam logic [XLEN_W-1:0] MTVEC_MASK = {{(XLEN_W-2){1'b1}}, 2'b01};

    // MPP is hardwired to M-mode, so only MIE/MPIE are real state.
    logic              st_mie, st_mpie;
    logic [XLEN_W-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN_W-1:0] mstatus_rd;
    logic [XLEN_W-1:0] rdata;

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE]                   = st_mie;
        mstatus_rd[MSTATUS_MPIE]                  = st_mpie;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

`ifdef MSRH_CSR_COUNTERS_EN
    logic [63:0] cyc, ins;

    msrh_csr_counter #(.XLEN_W(XLEN_W), .INC_W(1)) u_mcycle (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (1'b1),
        .i_wr_lo   (wr.valid && wr.addr == CSR_MCYCLE),
        .i_wr_hi   (wr.valid && XLEN_W == 32 && wr.addr == CSR_MCYCLEH),
        .i_wr_data (wr.data),
        .o_cnt     (cyc)
    );

    msrh_csr_counter #(.XLEN_W(XLEN_W), .INC_W(CNT_W)) u_minstret (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (i_commit_cnt),
        .i_wr_lo   (wr.valid && wr.addr == CSR_MINSTRET),
        .i_wr_hi   (wr.valid && XLEN_W == 32 && wr.addr == CSR_MINSTRETH),
        .i_wr_data (wr.data),
        .o_cnt     (ins)
    );
`else
    logic unused_commit;
    assign unused_commit = ^i_commit_cnt;
`endif

    // Read data is a pure function of the current registers, so a
    // same-cycle write is not forwarded.
    always_comb begin
        rdata = '0;
        case (rd.addr)
            CSR_MSTATUS:  rdata = mstatus_rd;
            CSR_MISA:     rdata = XLEN_W'(misa_val(XLEN_W));
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MHARTID:  rdata = XLEN_W'(HART_ID);
`ifdef MSRH_CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata = XLEN_W'(cyc);
            CSR_MINSTRET:  rdata = XLEN_W'(ins);
            CSR_MCYCLEH:   if (XLEN_W == 32) rdata = XLEN_W'(cyc[63:32]);
            CSR_MINSTRETH: if (XLEN_W == 32) rdata = XLEN_W'(ins[63:32]);
`endif
            default:      rdata = '0;
        endcase
    end

    assign rd.data = rdata;

    logic unused_rd_valid;
    assign unused_rd_valid = rd.valid;

    // Later assignments win: CSR write, then mret, then trap, applied per field.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            if (wr.valid) begin
                case (wr.addr)
                    CSR_MSTATUS: begin
                        st_mie  <= wr.data[MSTATUS_MIE];
                        st_mpie <= wr.data[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= wr.data;
                    CSR_MTVEC:    mtvec_q    <= wr.data & MTVEC_MASK;
                    CSR_MSCRATCH: mscratch_q <= wr.data;
                    CSR_MEPC:     mepc_q     <= wr.data & MEPC_MASK;
                    CSR_MCAUSE:   mcause_q   <= wr.data;
                    CSR_MTVAL:    mtval_q    <= wr.data;
                    default: ;
                endcase
            end
            if (i_mret_valid) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
            if (i_trap_valid) begin
                mepc_q   <= i_trap_pc & MEPC_MASK;
                mcause_q <= i_trap_cause;
                mtval_q  <= i_trap_tval;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end
        end
    end

    assign info.mepc        = mepc_q;
    assign info.mtvec       = mtvec_q;
    assign info.mstatus_mie = st_mie;

endmodule

// File: tb/tb_msrh_csr_file.sv
// Bench for msrh_csr_file (XLEN_W=64, HART_ID=5, CMT_W=2).
// Stimulus pushes expected values tagged with the cycle they apply to;
// a negedge monitor pops and compares against the DUT outputs.
module tb_msrh_csr_file;
    import msrh_csu_pkg::*;

    localparam int XL  = 64;
    localparam int HID = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trap_valid;
    logic [XL-1:0] trap_cause, trap_pc, trap_tval;
    logic          mret_valid;
    logic [1:0]    commit_cnt;

    always #5 clk = ~clk;

    csr_rd_if   #(.XLEN_W(XL)) rd_if ();
    csr_wr_if   #(.XLEN_W(XL)) wr_if ();
    csr_info_if #(.XLEN_W(XL)) info_if ();

    msrh_csr_file #(.HART_ID(HID), .CMT_W(2), .XLEN_W(XL)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .rd           (rd_if),
        .wr           (wr_if),
        .i_trap_valid (trap_valid),
        .i_trap_cause (trap_cause),
        .i_trap_pc    (trap_pc),
        .i_trap_tval  (trap_tval),
        .i_mret_valid (mret_valid),
        .i_commit_cnt (commit_cnt),
        .info         (info_if)
    );

    // sel: 0 read data, 1 o_mepc, 2 o_mtvec, 3 o_mstatus_mie
    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            c = sb.pop_front();
            case (c.sel)
                0:       act = rd_if.valid ? rd_if.data : 64'hDEAD_DEAD_DEAD_DEAD;
                1:       act = info_if.mepc;
                2:       act = info_if.mtvec;
                default: act = {63'd0, info_if.mstatus_mie};
            endcase
            checks++;
            if (act !== c.exp || c.cyc != cyc_cnt) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, act, c.exp, cyc_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_if.valid = 1'b0;
        wr_if.valid = 1'b0;
        trap_valid  = 1'b0;
        mret_valid  = 1'b0;
        commit_cnt  = 2'd0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] e, input string n);
        rd_if.valid = 1'b1;
        rd_if.addr  = a;
        sb.push_back('{cyc: cyc_cnt, sel: 0, exp: e, name: n});
    endtask

    task automatic ob(input int s, input logic [63:0] e, input string n);
        sb.push_back('{cyc: cyc_cnt, sel: s, exp: e, name: n});
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        wr_if.valid = 1'b1;
        wr_if.addr  = a;
        wr_if.data  = d;
    endtask

    task automatic trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
        trap_valid = 1'b1;
        trap_pc    = pc;
        trap_cause = cause;
        trap_tval  = tval;
    endtask

    initial begin
        rd_if.valid = 1'b0; rd_if.addr = '0;
        wr_if.valid = 1'b0; wr_if.addr = '0; wr_if.data = '0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
        mret_valid = 1'b0; commit_cnt = '0;

        // Reset held: everything cleared, a trap during reset is discarded.
        tick();
        rd(CSR_MSTATUS, 64'h1800, "rst_mstatus");
        ob(1, 64'h0, "rst_o_mepc");
        ob(2, 64'h0, "rst_o_mtvec");
        ob(3, 64'h0, "rst_o_mie");
        trap(64'h4444, 64'h3, 64'h9);
        tick();
        rd(CSR_MEPC, 64'h0, "rst_trap_mepc");
        ob(3, 64'h0, "rst_trap_o_mie");
        tick();
        rd(CSR_MCAUSE, 64'h0, "rst_mcause");
        tick();
        rd(CSR_MTVEC, 64'h0, "rst_mtvec");
        tick();
        rst_n = 1'b1;

        // Constant / RO / unimplemented reads.
        rd(CSR_MISA, 64'h8000_0000_0000_1100, "misa");
        tick();
        rd(CSR_MHARTID, 64'd5, "mhartid");
        wr(CSR_MHARTID, 64'h77);
        tick();
        rd(CSR_MHARTID, 64'd5, "mhartid_ro");
        wr(CSR_MIP, 64'hFF);
        tick();
        rd(CSR_MIP, 64'h0, "mip");
        tick();
        rd(12'h7C0, 64'h0, "unimpl");
        tick();

        // mtvec WARL and same-cycle read returns old value.
        wr(CSR_MTVEC, 64'h8000_0003);
        rd(CSR_MTVEC, 64'h0, "mtvec_same_cyc");
        tick();
        rd(CSR_MTVEC, 64'h8000_0001, "mtvec_next");
        ob(2, 64'h8000_0001, "o_mtvec");
        tick();

        // mstatus field masking.
        wr(CSR_MSTATUS, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd(CSR_MSTATUS, 64'h1888, "mstatus_ones");
        ob(3, 64'h1, "o_mie_set");
        wr(CSR_MSTATUS, 64'h8);
        tick();
        rd(CSR_MSTATUS, 64'h1808, "mstatus_mie_only");

        // Trap with MIE=1, then mret.
        trap(64'h1001, 64'h2, 64'h33);
        tick();
        rd(CSR_MEPC, 64'h1000, "trap_mepc");
        ob(1, 64'h1000, "trap_o_mepc");
        ob(3, 64'h0, "trap_o_mie");
        tick();
        rd(CSR_MCAUSE, 64'h2, "trap_mcause");
        tick();
        rd(CSR_MTVAL, 64'h33, "trap_mtval");
        tick();
        rd(CSR_MSTATUS, 64'h1880, "trap_mstatus");
        mret_valid = 1'b1;
        tick();
        rd(CSR_MSTATUS, 64'h1888, "mret_mstatus");
        ob(3, 64'h1, "mret_o_mie");

        // Trap beats a mepc write; unrelated write still lands.
        trap(64'h2000, 64'h4, 64'h0);
        wr(CSR_MEPC, 64'h55);
        tick();
        rd(CSR_MEPC, 64'h2000, "trap_over_wr_mepc");
        trap(64'h3000, 64'h5, 64'h0);
        wr(CSR_MSCRATCH, 64'hABCD);
        tick();
        rd(CSR_MSCRATCH, 64'hABCD, "trap_mscratch_wr");
        ob(1, 64'h3000, "trap2_o_mepc");
        tick();
        rd(CSR_MSTATUS, 64'h1800, "trap2_mstatus");
        // mret beats a same-cycle mstatus write.
        mret_valid = 1'b1;
        wr(CSR_MSTATUS, 64'h8);
        tick();
        rd(CSR_MSTATUS, 64'h1880, "mret_over_wr");
        ob(3, 64'h0, "mret_over_wr_o_mie");

        wr(CSR_MEPC, 64'h1235);
        tick();
        rd(CSR_MEPC, 64'h1234, "mepc_warl");
        wr(CSR_MCAUSE, 64'h8000_0000_0000_0007);
        tick();
        rd(CSR_MCAUSE, 64'h8000_0000_0000_0007, "mcause_wr");
        wr(CSR_MIE, 64'h888);
        tick();
        rd(CSR_MIE, 64'h888, "mie_wr");
        tick();

`ifdef MSRH_CSR_COUNTERS_EN
        wr(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_wr");
        tick();
        rd(CSR_MCYCLE, 64'h0, "mcycle_wrap");
        tick();
        rd(CSR_MCYCLE, 64'h1, "mcycle_inc");
        wr(CSR_MINSTRET, 64'd100);
        commit_cnt = 2'd2;
        tick();
        rd(CSR_MINSTRET, 64'd100, "minstret_wr_override");
        for (int i = 0; i < 5; i++) begin
            commit_cnt = 2'd2;
            tick();
        end
        rd(CSR_MINSTRET, 64'd110, "minstret_plus10");
        tick();
`else
        repeat (100) tick();
        rd(CSR_MCYCLE, 64'h0, "mcycle_off_idle");
        wr(CSR_MCYCLE, 64'h5);
        commit_cnt = 2'd2;
        tick();
        rd(CSR_MCYCLE, 64'h0, "mcycle_off_wr");
        tick();
        rd(CSR_MINSTRET, 64'h0, "minstret_off");
        tick();
`endif

        tick();
        tick();
        if (sb.size() != 0)
            $display("FAIL drain: %0d checks left unchecked, expected 0", sb.size());
        $display("Result: errors=%0d of %0d checks", errors + sb.size(), checks + sb.size());
        $finish;
    end

endmodule
